// File: rtl/alu_arb.sv
// alu_arb: two-requester round-robin front end for one shared ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_OVF_EN to report signed overflow on rsp_V and ovf_sticky; otherwise both read 0.
module alu_arb #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_A,
  input  logic [31:0] r0_B,
  input  logic [5:0]  r0_ALUFun,
  input  logic        r0_Sign,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_A,
  input  logic [31:0] r1_B,
  input  logic [5:0]  r1_ALUFun,
  input  logic        r1_Sign,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [5:0]  alu_ALUFun,
  output logic        alu_Sign,
  input  logic [31:0] alu_Z,
  input  logic        alu_V,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_Z,
  output logic        rsp_V,
  input  logic        rsp_ready,
  output logic        ovf_sticky
);
`ifdef ALU_ARB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q;
  logic        last_q, id_q, v_q, ovf_q, sign_q;
  logic [31:0] a_q, b_q, z_q;
  logic [5:0]  fun_q;
  logic        idle, g0, g1;
  // on contention the port that did not win last time gets the grant
  assign idle     = (state_q == IDLE) & ~reset;
  assign g0       = r0_valid & (~r1_valid | last_q);
  assign g1       = r1_valid & (~r0_valid | ~last_q);
  assign r0_ready = idle & g0;
  assign r1_ready = idle & g1;
  assign alu_A      = a_q;
  assign alu_B      = b_q;
  assign alu_ALUFun = fun_q;
  assign alu_Sign   = sign_q;
  assign rsp_valid  = state_q == RESP;
  assign rsp_id     = id_q;
  assign rsp_Z      = z_q;
  assign rsp_V      = v_q;
  assign ovf_sticky = ovf_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= ~PRIO_INIT;
      id_q    <= 1'b0;
      z_q     <= '0;
      v_q     <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      sign_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (r0_ready | r1_ready) begin
        a_q     <= r1_ready ? r1_A : r0_A;
        b_q     <= r1_ready ? r1_B : r0_B;
        fun_q   <= r1_ready ? r1_ALUFun : r0_ALUFun;
        sign_q  <= r1_ready ? r1_Sign : r0_Sign;
        id_q    <= r1_ready;
        last_q  <= r1_ready;
        state_q <= EXEC;
      end
    end else if (state_q == EXEC) begin
      z_q     <= alu_Z;
      v_q     <= OVF_EN & alu_V;
      ovf_q   <= OVF_EN & (ovf_q | (alu_V & sign_q));
      state_q <= RESP;
    end else begin
      state_q <= rsp_ready ? IDLE : RESP;
    end
  end
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: randomized scoreboard bench for alu_arb with a behavioural ALU and arbitration model.
module tb_alu_arb;
`ifdef ALU_ARB_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam bit PRIO = 1'b0;
  logic        clk = 1'b0, reset = 1'b1;
  logic        r0_valid = 1'b0, r1_valid = 1'b0, r0_ready, r1_ready;
  logic [31:0] r0_A = '0, r0_B = '0, r1_A = '0, r1_B = '0;
  logic [5:0]  r0_ALUFun = '0, r1_ALUFun = '0;
  logic        r0_Sign = 1'b0, r1_Sign = 1'b0;
  logic [31:0] alu_A, alu_B, alu_Z, rsp_Z;
  logic [5:0]  alu_ALUFun;
  logic        alu_Sign, alu_V, rsp_valid, rsp_id, rsp_V, ovf_sticky;
  logic        rsp_ready = 1'b1;
  int          checks = 0, errors = 0, cyc = 0;

  typedef struct packed {logic id; logic [31:0] z; logic v;} exp_t;
  exp_t        q[$];
  bit          gl[$];
  bit          busy = 1'b0, last = ~PRIO, exp_ovf = 1'b0, pend_ovf = 1'b0;
  int          hs = 0;
  logic [31:0] exp_a = '0;

  alu_arb #(.PRIO_INIT(PRIO)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_A(r0_A), .r0_B(r0_B), .r0_ALUFun(r0_ALUFun), .r0_Sign(r0_Sign),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_A(r1_A), .r1_B(r1_B), .r1_ALUFun(r1_ALUFun), .r1_Sign(r1_Sign),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUFun(alu_ALUFun), .alu_Sign(alu_Sign), .alu_Z(alu_Z), .alu_V(alu_V),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_Z(rsp_Z), .rsp_V(rsp_V), .rsp_ready(rsp_ready),
    .ovf_sticky(ovf_sticky)
  );

  // ALU reference: ADD, SUB, otherwise XOR; V is signed overflow in signed mode
  function automatic logic [32:0] alu_f(input logic [31:0] a, b, input logic [5:0] f, input logic s);
    logic [31:0] z;
    logic v;
    z = f == 6'd0 ? a + b : f == 6'd1 ? a - b : a ^ b;
    v = s & (f == 6'd0 ? (a[31] == b[31] && z[31] != a[31]) :
             f == 6'd1 ? (a[31] != b[31] && z[31] != a[31]) : 1'b0);
    return {v, z};
  endfunction

  assign {alu_V, alu_Z} = alu_f(alu_A, alu_B, alu_ALUFun, alu_Sign);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // monitor: arbitration/latency model plus scoreboard pop on each presented response
  always @(negedge clk) begin
    bit g0, g1;
    logic [32:0] r;
    if (reset) begin
      chk("rst_r0_ready", 32'(r0_ready), 0);
      chk("rst_r1_ready", 32'(r1_ready), 0);
      busy = 1'b0; last = ~PRIO; exp_a = '0; exp_ovf = 1'b0; q.delete();
    end else begin
      g0 = !busy && r0_valid && (!r1_valid || last);
      g1 = !busy && r1_valid && (!r0_valid || !last);
      chk("r0_ready", 32'(r0_ready), 32'(g0));
      chk("r1_ready", 32'(r1_ready), 32'(g1));
      chk("alu_A", alu_A, exp_a);
      chk("rsp_valid", 32'(rsp_valid), 32'(busy && (cyc - hs >= 2)));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(exp_ovf));
      if (rsp_valid && q.size() > 0) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_Z", rsp_Z, q[0].z);
        chk("rsp_V", 32'(rsp_V), 32'(q[0].v));
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        busy = 1'b0;
      end
      if (busy && cyc == hs + 1 && pend_ovf) exp_ovf = OVF_EN;
      if (g0 || g1) begin
        r = g1 ? alu_f(r1_A, r1_B, r1_ALUFun, r1_Sign) : alu_f(r0_A, r0_B, r0_ALUFun, r0_Sign);
        q.push_back('{id: g1, z: r[31:0], v: OVF_EN & r[32]});
        gl.push_back(g1);
        pend_ovf = r[32];
        busy = 1'b1; hs = cyc; last = g1;
        exp_a = g1 ? r1_A : r0_A;
      end
    end
  end

  task automatic set_req(input bit id, input logic [31:0] a, b, input logic [5:0] f, input logic s);
    if (id) begin r1_A = a; r1_B = b; r1_ALUFun = f; r1_Sign = s; r1_valid = 1'b1; end
    else    begin r0_A = a; r0_B = b; r0_ALUFun = f; r0_Sign = s; r0_valid = 1'b1; end
  endtask

  task automatic issue(input bit id, input logic [31:0] a, b, input logic [5:0] f, input logic s);
    bit acc = 1'b0;
    set_req(id, a, b, f, s);
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = id ? (r1_valid & r1_ready) : (r0_valid & r0_ready);
    end
    chk("issue_accept", 32'(acc), 1);
    @(posedge clk); #1;
    if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(posedge clk);
    chk("idle_timeout", 32'(busy), 0);
    #1;
  endtask

  task automatic rand_req(input bit id);
    logic [5:0] f;
    f = 6'($urandom % 3 == 2 ? 22 : $urandom % 2);
    set_req(id, $urandom, $urandom, f, 1'($urandom % 2));
    if ($urandom % 3 == 0) begin
      if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
    end
  endtask

  initial begin
    bit a0, a1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_Z", rsp_Z, 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_alu_A", alu_A, 0);
    @(posedge clk); #1;
    // single ADD
    issue(1'b0, 32'd5, 32'd7, 6'd0, 1'b0);
    wait_idle();
    // contention from reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; gl.delete();
    set_req(1'b0, 32'd10, 32'd1, 6'd0, 1'b0);
    set_req(1'b1, 32'd20, 32'd2, 6'd1, 1'b0);
    repeat (13) @(posedge clk);
    #1 r0_valid = 1'b0; r1_valid = 1'b0;
    chk("contention_count", 32'(gl.size() >= 4), 1);
    for (int i = 0; i < 4 && i < gl.size(); i++) chk("contention_order", 32'(gl[i]), 32'(i % 2));
    wait_idle();
    // back-pressure with operand change on the stalled requester
    rsp_ready = 1'b0;
    issue(1'b1, 32'h11, 32'h22, 6'd0, 1'b0);
    r1_A = 32'hdead;
    set_req(1'b0, 32'h100, 32'h1, 6'd1, 1'b0);
    repeat (6) @(posedge clk);
    #1 rsp_ready = 1'b1;
    issue(1'b0, 32'h100, 32'h1, 6'd1, 1'b0);
    wait_idle();
    // signed overflow
    issue(1'b0, 32'h7fffffff, 32'd1, 6'd0, 1'b1);
    wait_idle();
    chk("ovf_after", 32'(ovf_sticky), 32'(OVF_EN));
    repeat (4) @(posedge clk);
    #1 chk("ovf_hold", 32'(ovf_sticky), 32'(OVF_EN));
    // reset while in EXEC
    issue(1'b1, 32'd3, 32'd4, 6'd0, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midop_alu_A", alu_A, 0);
    chk("midop_rsp_valid", 32'(rsp_valid), 0);
    @(posedge clk); #1;
    // randomized traffic
    repeat (3000) begin
      @(negedge clk);
      a0 = r0_valid & r0_ready;
      a1 = r1_valid & r1_ready;
      @(posedge clk); #1;
      if (a0 || !r0_valid) rand_req(1'b0); else if ($urandom % 10 == 0) r0_valid = 1'b0;
      if (a1 || !r1_valid) rand_req(1'b1); else if ($urandom % 10 == 0) r1_valid = 1'b0;
      rsp_ready = $urandom % 3 != 0;
      reset = $urandom % 250 == 0;
    end
    reset = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
